// File: rtl/aes_pkg.sv
// Shared AES-128 decryption definitions: FSM encoding, round constants,
// inverse S-box and the InvShiftRows / InvSubBytes helpers.
package aes_pkg;

  localparam int unsigned BLK_W     = 128;
  localparam int unsigned RND_W     = 4;
  localparam int unsigned NR_AES128 = 10;

  localparam logic [RND_W-1:0] RK_IDX_FIRST = RND_W'(NR_AES128);
  localparam logic [RND_W-1:0] RK_IDX_FINAL = 4'd0;
  localparam logic [RND_W-1:0] RND_LAST     = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Entry for byte value v sits at bits [8*(255-v) +: 8]
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[8*(255 - int'(b)) +: 8];
  endfunction

  // Byte k of the block is bits [127-8k -: 8]; k = row + 4*col
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c-row+4)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_inv_mix.sv
// InvMixColumns over a full 128-bit column-major state, purely combinational.
module aes_inv_round_ctrl_inv_mix
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  output logic [BLK_W-1:0] mixed_c
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant, built from doublings
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? b  : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  always_comb begin
    mixed_c = '0;
    for (int c = 0; c < 4; c++) begin
      mixed_c[127-32*c -: 32] = inv_mix_col(state[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched
// from an external store by index, valid/ready handshakes on both sides.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_AES128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_W-1:0]   in_data,
  output logic [RND_W-1:0]   rk_idx,
  input  logic [BLK_W-1:0]   rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_W-1:0]   out_data,
  output logic               busy
);

  localparam logic [RND_W-1:0] RK_FIRST = RND_W'(NR);
  localparam logic [RND_W-1:0] RND_INIT = RND_W'(NR - 1);

  state_t             st_q, st_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [BLK_W-1:0]   sub_key;
  logic [BLK_W-1:0]   mixed;
  logic               in_ready_d, out_valid_d, busy_d;
  logic [RND_W-1:0]   rk_idx_d;

  // Shared front half of ROUND and FINAL; only ROUND goes on through InvMixColumns
  assign sub_key = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_data;

  aes_inv_round_ctrl_inv_mix u_inv_mix (
    .state   (sub_key),
    .mixed_c (mixed)
  );

  assign out_data = blk_q;

  always_comb begin
    st_d        = st_q;
    rnd_d       = rnd_q;
    blk_d       = blk_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    rk_idx_d    = RK_IDX_FINAL;

    case (st_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d = in_data ^ rk_data;
          rnd_d = RND_INIT;
          st_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        blk_d = mixed;
        if (rnd_q <= RND_LAST) begin
          rnd_d = '0;
          st_d  = ST_FINAL;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      ST_FINAL: begin
        blk_d = sub_key;
        st_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          st_d = ST_IDLE;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        rnd_d = '0;
      end
    endcase

    // Handshake and key-index outputs are registered from the next state
    case (st_d)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        rk_idx_d   = RK_FIRST;
      end
      ST_ROUND: rk_idx_d    = rnd_d;
      ST_DONE:  out_valid_d = 1'b1;
      default:  rk_idx_d    = RK_IDX_FINAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      rnd_q     <= '0;
      blk_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rk_idx    <= RK_FIRST;
    end else begin
      st_q      <= st_d;
      rnd_q     <= rnd_d;
      blk_q     <= blk_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      rk_idx    <= rk_idx_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using FIPS-197 vectors and a
// table-driven model of the external round-key store.
module tb_aes_inv_round_ctrl;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;
  logic         key_sel;
  logic [127:0] c1_rk [16];
  logic [127:0] b_rk  [16];
  logic [127:0] imc_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rk_data = key_sel ? b_rk[rk_idx] : c1_rk[rk_idx];

  aes_inv_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Standalone InvMixColumns reference vector
  aes_inv_round_ctrl_inv_mix u_imc_ref (
    .state   (128'h2ec27d03c428e061c5529e8f9d9a53de),
    .mixed_c (imc_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 30) begin
      step();
      edges++;
    end
  endtask

  int edges;
  int seen;
  int cyc;
  int exp_rk;
  logic [3:0]   rk_log[$];
  int           acc_cyc[$];
  logic [127:0] res[$];

  initial begin
    for (int i = 0; i < 16; i++) begin
      c1_rk[i] = '0;
      b_rk[i]  = '0;
    end
    c1_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    c1_rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    c1_rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    c1_rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    c1_rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    c1_rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    c1_rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    c1_rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    c1_rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    c1_rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    c1_rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    b_rk[0]   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    b_rk[1]   = 128'ha0fafe1788542cb123a339392a6c7605;
    b_rk[2]   = 128'hf2c295f27a96b9435935807a7359f67f;
    b_rk[3]   = 128'h3d80477d4716fe3e1e237e446d7a883b;
    b_rk[4]   = 128'hef44a541a8525b7fb671253bdb0bad00;
    b_rk[5]   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    b_rk[6]   = 128'h6d88a37a110b3efddbf98641ca0093fd;
    b_rk[7]   = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    b_rk[8]   = 128'head27321b58dbad2312bf5607f8d292f;
    b_rk[9]   = 128'hac7766f319fadc2128d12941575c006e;
    b_rk[10]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; key_sel = 1'b0;
    step();
    step();
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_out_data",  out_data,        128'd0);
    check("rst_rk_idx",    128'(rk_idx),    128'd10);
    rst = 1'b0;
    step();
    check("idle_hold_in_ready", 128'(in_ready), 128'd1);

    check("imc_vector", imc_out, 128'hd4e0b81ebfb441275d52119830aef1e5);

    // C.1 block with a stalled consumer
    in_data = C1_CT; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("c1_busy",     128'(busy),     128'd1);
    check("c1_in_ready", 128'(in_ready), 128'd0);
    check("c1_rk_first", 128'(rk_idx),   128'd9);
    wait_done(edges);
    check("c1_latency",  128'(edges),    128'd10);
    check("c1_out_data", out_data,       C1_PT);
    check("c1_done_rk",  128'(rk_idx),   128'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_out_data",  out_data,        C1_PT);
      check("stall_in_ready",  128'(in_ready),  128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_in_ready",  128'(in_ready),  128'd1);
    check("release_out_valid", 128'(out_valid), 128'd0);
    check("release_busy",      128'(busy),      128'd0);
    check("release_rk_idx",    128'(rk_idx),    128'd10);

    // Appendix B block with a foreign in_valid pulse while busy
    key_sel = 1'b1; in_data = B_CT; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    in_data = C1_CT; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    check("pulse_in_ready", 128'(in_ready), 128'd0);
    check("pulse_rk_idx",   128'(rk_idx),   128'd4);
    wait_done(edges);
    check("b_latency",  128'(edges), 128'd5);
    check("b_out_data", out_data,    B_PT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset in the middle of ROUND
    key_sel = 1'b0; in_data = C1_CT; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    check("mid_rk_idx5", 128'(rk_idx), 128'd5);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("mrst_in_ready",  128'(in_ready),  128'd1);
    check("mrst_out_valid", 128'(out_valid), 128'd0);
    check("mrst_out_data",  out_data,        128'd0);
    check("mrst_busy",      128'(busy),      128'd0);
    check("mrst_rk_idx",    128'(rk_idx),    128'd10);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mrst_no_pulse", 128'(seen), 128'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(edges);
    check("mrst_c1_latency",  128'(edges), 128'd10);
    check("mrst_c1_out_data", out_data,    C1_PT);
    out_ready = 1'b1;
    step();

    // Back-to-back C.1 then B with in_valid and out_ready tied high
    key_sel = 1'b0; in_data = C1_CT; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (res.size() < 2 && cyc < 60) begin
      rk_log.push_back(rk_idx);
      if (in_ready) acc_cyc.push_back(cyc);
      if (out_valid) begin
        res.push_back(out_data);
        key_sel = 1'b1;
        in_data = B_CT;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_result_count", 128'(res.size()),     128'd2);
    check("b2b_accept_count", 128'(acc_cyc.size()), 128'd2);
    check("b2b_rk_log_len",   128'(rk_log.size()),  128'd24);
    if (res.size() >= 2) begin
      check("b2b_c1_out_data", res[0], C1_PT);
      check("b2b_b_out_data",  res[1], B_PT);
    end
    if (acc_cyc.size() >= 2) begin
      check("b2b_accept_period", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    end
    for (int i = 0; i < rk_log.size(); i++) begin
      exp_rk = i % 12;
      exp_rk = (exp_rk == 0) ? 10 : (exp_rk >= 10) ? 0 : 10 - exp_rk;
      check("b2b_rk_seq", 128'(rk_log[i]), 128'(exp_rk));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of AES-128 decryption rounds; only 10 is supported.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning ciphertext block offered.
REQ-005 SHALL have port in_ready, output, 1, meaning block can be accepted.
REQ-006 SHALL have port in_data, input, 128, meaning ciphertext, FIPS-197 byte order (byte 0 = bits 127:120, column-major).
REQ-007 SHALL have port rk_idx, output, 4, meaning index 0..10 of the round key requested this cycle.
REQ-008 SHALL have port rk_data, input, 128, meaning round key rk_idx, combinationally valid in the same cycle (external key store).
REQ-009 SHALL have port out_valid, output, 1, meaning plaintext block available.
REQ-010 SHALL have port out_ready, input, 1, meaning consumer accepts plaintext.
REQ-011 SHALL have port out_data, output, 128, meaning plaintext, same byte order as in_data.
REQ-012 SHALL have port busy, output, 1, meaning high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, FINAL, DONE, with a 4-bit round counter rnd.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; no overlap of input and output transfers.
REQ-015 rk_idx SHALL be 10 in IDLE, rnd in ROUND, 0 in FINAL, and 0 in DONE.
REQ-016 IDLE, in_valid=1: state <= in_data XOR rk_data, rnd <= 9, go ROUND; in_valid=0: hold.
REQ-017 ROUND: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk_data), rnd <= rnd-1; when rnd=1, go FINAL instead of staying.
REQ-018 FINAL: state <= InvSubBytes(InvShiftRows(state)) XOR rk_data (no InvMixColumns), go DONE.
REQ-019 DONE: out_data = state register, held stable while out_valid=1 and out_ready=0; out_ready=1 -> go IDLE next edge.
REQ-020 Latency: out_valid SHALL rise after exactly 10 rising edges following the accepting edge; minimum block-to-block period 12 cycles with out_ready tied high.
REQ-021 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT alter state or rnd.
REQ-022 rnd SHALL never wrap: values outside 1..9 SHALL not occur in ROUND; an illegal state encoding SHALL return to IDLE.
REQ-023 out_data SHALL be the state register in all states (no gating); consumers qualify with out_valid.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, rnd=0, state register=0, hence in_ready=1, out_valid=0, busy=0, out_data=0, rk_idx=10 in the following cycle.
REQ-025 rst mid-operation (ROUND/FINAL/DONE) SHALL discard the block in flight with no out_valid pulse; rst has priority over every handshake in the same cycle.

Structure
REQ-026 Inverse S-box table, FSM state encoding, NR and round-key index constants SHALL reside in a shared package (aes_pkg).
REQ-027 InvShiftRows and InvSubBytes SHALL be package functions; the existing InvMixColumns module SHALL be instantiated once as the sole sub-module, on the ROUND datapath.
REQ-028 SHALL contain one 128-bit state register; no key expansion inside this block.

Verification
REQ-029 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (model key store), in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid 10 edges after accept.
REQ-030 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3925841d02dc09fbdc118597196a0b32 -> out_data 3243f6a8885a308d313198a2e0370734; internal InvMixColumns input 2ec27d03c428e061c5529e8f9d9a53de -> d4e0b81ebfb441275d52119830aef1e5 checked.
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-032 in_valid pulsed during ROUND with a different block -> ignored; first block's result unchanged.
REQ-033 rst asserted in ROUND at rnd=5 -> next cycle IDLE, out_valid=0, out_data=0; a fresh C.1 block then decrypts correctly.
REQ-034 Back-to-back C.1 and B blocks, in_valid and out_ready tied high -> correct results, accepts exactly 12 cycles apart, rk_idx sequence 10,9..1,0 per block.
